// File: rtl/pe_mac_sa.sv
// Processing element for the convolution systolic array: stationary weight
// shift chain, one-cycle feature forwarding and a 2-stage signed/saturating MAC.
module pe_mac_sa #(
    parameter int DW     = 8,
    parameter int PW     = 20,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          compute_SA,
    input  logic          clear,
    input  logic          mode,
    input  logic          w_load,
    input  logic [DW-1:0] w_in,
    output logic [DW-1:0] w_out,
    input  logic          f_valid_in,
    input  logic [DW-1:0] f_in,
    output logic          f_valid_out,
    output logic [DW-1:0] f_out,
    input  logic [PW-1:0] psum_in,
    input  logic          drain,
    output logic          psum_valid_out,
    output logic [PW-1:0] psum_out,
    output logic          sat_flag
);

    localparam int EXT = PW + 1 - 2 * DW;
    localparam logic [PW-1:0] S_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] S_MIN = {1'b1, {(PW-1){1'b0}}};
    localparam logic [PW-1:0] U_MAX = {PW{1'b1}};

    logic [DW-1:0]   w_reg;
    logic [2*DW-1:0] prod_c;
    logic [2*DW-1:0] prod;
    logic            v1;
    logic            drain_d;
    logic [PW-1:0]   psum_d;
    logic [PW-1:0]   acc;

    logic [PW-1:0]   add_a;
    logic [2*DW-1:0] prod_m;
    logic            sx_a;
    logic            sx_b;
    logic [PW:0]     ext_a;
    logic [PW:0]     ext_b;
    logic [PW:0]     sum;
    logic            ovf;
    logic [PW-1:0]   clamp_val;
    logic [PW-1:0]   res;
    logic            sat_hit;

    // Operands are widened to 2*DW before multiplying so the low 2*DW bits
    // of the product are exact for either signedness.
    generate
        if (SIGNED != 0) begin : g_smul
            assign prod_c = $signed({{DW{f_in[DW-1]}}, f_in})
                          * $signed({{DW{w_reg[DW-1]}}, w_reg});
        end else begin : g_umul
            assign prod_c = {{DW{1'b0}}, f_in} * {{DW{1'b0}}, w_reg};
        end
    endgenerate

    assign w_out = w_reg;

    // One PW+1 bit adder serves both modes: the pass-through sum in mode 0
    // and the local accumulator update in mode 1.
    always_comb begin
        add_a     = mode ? acc : psum_d;
        prod_m    = (mode && !v1) ? '0 : prod;
        sx_a      = (SIGNED != 0) && add_a[PW-1];
        sx_b      = (SIGNED != 0) && prod_m[2*DW-1];
        ext_a     = {sx_a, add_a};
        ext_b     = {{EXT{sx_b}}, prod_m};
        sum       = ext_a + ext_b;
        ovf       = 1'b0;
        clamp_val = U_MAX;
        if (SIGNED != 0) begin
            ovf       = sum[PW] ^ sum[PW-1];
            clamp_val = sum[PW] ? S_MIN : S_MAX;
        end else begin
            ovf       = sum[PW];
            clamp_val = U_MAX;
        end
        res     = sum[PW-1:0];
        sat_hit = 1'b0;
        if ((SAT != 0) && ovf) begin
            res     = clamp_val;
            sat_hit = 1'b1;
        end
    end

    // The weight chain ignores compute_SA and clear so weights can be
    // preloaded while the array is stalled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            w_reg <= '0;
        end else if (w_load) begin
            w_reg <= w_in;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            f_out          <= '0;
            f_valid_out    <= 1'b0;
            prod           <= '0;
            v1             <= 1'b0;
            psum_d         <= '0;
            drain_d        <= 1'b0;
            acc            <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            sat_flag       <= 1'b0;
        end else if (clear) begin
            acc            <= '0;
            sat_flag       <= 1'b0;
            v1             <= 1'b0;
            drain_d        <= 1'b0;
            psum_valid_out <= 1'b0;
        end else if (compute_SA) begin
            f_out       <= f_in;
            f_valid_out <= f_valid_in;
            prod        <= prod_c;
            v1          <= f_valid_in;
            psum_d      <= psum_in;
            drain_d     <= drain;
            if (!mode) begin
                if (v1) begin
                    psum_out       <= res;
                    psum_valid_out <= 1'b1;
                    if (sat_hit) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    psum_valid_out <= 1'b0;
                end
            end else begin
                if (sat_hit) begin
                    sat_flag <= 1'b1;
                end
                // A product landing in the drain cycle is part of the drained value.
                if (drain_d) begin
                    psum_out       <= res;
                    psum_valid_out <= 1'b1;
                    acc            <= '0;
                end else begin
                    acc            <= res;
                    psum_valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_sa.sv
// Directed self-checking bench for pe_mac_sa: weight chain, both modes,
// saturation, stall and asynchronous reset mid-stream.
module tb_pe_mac_sa;

    localparam int DW = 8;
    localparam int PW = 20;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    logic          compute_SA = 1'b0;
    logic          clear = 1'b0;
    logic          mode = 1'b0;
    logic          w_load = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          f_valid_in = 1'b0;
    logic [DW-1:0] f_in = '0;
    logic [PW-1:0] psum_in = '0;
    logic          drain = 1'b0;

    logic [DW-1:0] w_out0, w_out1, w_out2;
    logic          f_valid_out, fv1, fv2;
    logic [DW-1:0] f_out, fo1, fo2;
    logic          psum_valid_out, pv1, pv2;
    logic [PW-1:0] psum_out, po1, po2;
    logic          sat_flag, sf1, sf2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pe_mac_sa #(.DW(DW), .PW(PW), .SIGNED(1), .SAT(1)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .compute_SA(compute_SA), .clear(clear), .mode(mode),
        .w_load(w_load), .w_in(w_in), .w_out(w_out0),
        .f_valid_in(f_valid_in), .f_in(f_in), .f_valid_out(f_valid_out), .f_out(f_out),
        .psum_in(psum_in), .drain(drain), .psum_valid_out(psum_valid_out),
        .psum_out(psum_out), .sat_flag(sat_flag)
    );

    pe_mac_sa #(.DW(DW), .PW(PW), .SIGNED(1), .SAT(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .compute_SA(compute_SA), .clear(clear), .mode(mode),
        .w_load(w_load), .w_in(w_out0), .w_out(w_out1),
        .f_valid_in(f_valid_in), .f_in(f_in), .f_valid_out(fv1), .f_out(fo1),
        .psum_in(psum_in), .drain(drain), .psum_valid_out(pv1),
        .psum_out(po1), .sat_flag(sf1)
    );

    pe_mac_sa #(.DW(DW), .PW(PW), .SIGNED(1), .SAT(1)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .compute_SA(compute_SA), .clear(clear), .mode(mode),
        .w_load(w_load), .w_in(w_out1), .w_out(w_out2),
        .f_valid_in(f_valid_in), .f_in(f_in), .f_valid_out(fv2), .f_out(fo2),
        .psum_in(psum_in), .drain(drain), .psum_valid_out(pv2),
        .psum_out(po2), .sat_flag(sf2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        #3;
        chk("rst_w_out", 32'(w_out0), 0);
        chk("rst_f_out", 32'(f_out), 0);
        chk("rst_f_valid_out", 32'(f_valid_out), 0);
        chk("rst_psum_out", 32'(psum_out), 0);
        chk("rst_psum_valid_out", 32'(psum_valid_out), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        #8 Rst_n = 1'b1;

        // weight chain: 5,6,7 shifted through three PEs
        w_load = 1'b1; w_in = 8'd5; tick();
        w_in = 8'd6; tick();
        w_in = 8'd7; tick();
        w_load = 1'b0;
        chk("chain_pe0", 32'(w_out0), 7);
        chk("chain_pe1", 32'(w_out1), 6);
        chk("chain_pe2", 32'(w_out2), 5);

        // mode 0 signed: -3*12 + 100 = 64
        compute_SA = 1'b1; mode = 1'b0;
        w_load = 1'b1; w_in = 8'hFD; tick();
        w_load = 1'b0;
        f_in = 8'd12; f_valid_in = 1'b1; psum_in = 20'd100;
        tick();
        chk("m0_f_out", 32'(f_out), 12);
        chk("m0_f_valid_out", 32'(f_valid_out), 1);
        chk("m0_not_yet_valid", 32'(psum_valid_out), 0);
        f_in = '0; f_valid_in = 1'b0; psum_in = '0;
        tick();
        chk("m0_psum_out", 32'(psum_out), 64);
        chk("m0_psum_valid", 32'(psum_valid_out), 1);
        tick();
        chk("m0_valid_drops", 32'(psum_valid_out), 0);
        chk("m0_psum_holds", 32'(psum_out), 64);

        // saturation both directions, back-to-back
        w_load = 1'b1; w_in = 8'd100; tick();
        w_load = 1'b0;
        f_in = 8'd100; f_valid_in = 1'b1; psum_in = 20'd524000;
        tick();
        f_in = 8'h9C; psum_in = 20'd524576;
        tick();
        chk("sat_pos_psum", 32'(psum_out), 'h7FFFF);
        chk("sat_pos_flag", 32'(sat_flag), 1);
        f_valid_in = 1'b0; f_in = '0; psum_in = '0;
        tick();
        chk("sat_neg_psum", 32'(psum_out), 'h80000);
        chk("sat_neg_valid", 32'(psum_valid_out), 1);
        chk("sat_flag_sticky", 32'(sat_flag), 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_sat_flag", 32'(sat_flag), 0);
        chk("clear_valid", 32'(psum_valid_out), 0);
        chk("clear_psum_holds", 32'(psum_out), 'h80000);

        // mode 1: 2*(1+2+3+4) = 20 drained, then 2*1 = 2
        w_load = 1'b1; w_in = 8'd2; tick();
        w_load = 1'b0; mode = 1'b1;
        f_valid_in = 1'b1; f_in = 8'd1; tick();
        f_in = 8'd2; tick();
        f_in = 8'd3; tick();
        chk("m1_no_output", 32'(psum_valid_out), 0);
        f_in = 8'd4; drain = 1'b1; tick();
        f_valid_in = 1'b0; f_in = '0; drain = 1'b0;
        tick();
        chk("m1_drain_value", 32'(psum_out), 20);
        chk("m1_drain_valid", 32'(psum_valid_out), 1);
        f_valid_in = 1'b1; f_in = 8'd1; tick();
        chk("m1_single_valid", 32'(psum_valid_out), 0);
        f_valid_in = 1'b0; f_in = '0; drain = 1'b1; tick();
        drain = 1'b0;
        chk("m1_wait_valid", 32'(psum_valid_out), 0);
        tick();
        chk("m1_second_drain", 32'(psum_out), 2);
        chk("m1_second_valid", 32'(psum_valid_out), 1);

        // stall mid-stream with a weight load during the stall
        mode = 1'b0;
        f_valid_in = 1'b1; f_in = 8'd1; psum_in = 20'd10; tick();
        f_in = 8'd2; psum_in = 20'd20; tick();
        chk("stall_pre_out", 32'(psum_out), 12);
        compute_SA = 1'b0;
        f_in = 8'd3; psum_in = 20'd30;
        w_load = 1'b1; w_in = 8'd3; tick();
        w_load = 1'b0;
        chk("stall_wload", 32'(w_out0), 3);
        tick(); tick();
        chk("stall_psum_frozen", 32'(psum_out), 12);
        chk("stall_valid_frozen", 32'(psum_valid_out), 1);
        chk("stall_f_out_frozen", 32'(f_out), 2);
        compute_SA = 1'b1; tick();
        chk("resume_out_b", 32'(psum_out), 24);
        chk("resume_valid_b", 32'(psum_valid_out), 1);
        f_valid_in = 1'b0; f_in = '0; psum_in = '0; tick();
        chk("resume_out_c", 32'(psum_out), 39);
        tick();
        chk("resume_valid_drops", 32'(psum_valid_out), 0);

        // asynchronous reset between pipeline stages
        f_valid_in = 1'b1; f_in = 8'd5; tick();
        f_valid_in = 1'b0; f_in = '0;
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_psum_out", 32'(psum_out), 0);
        chk("arst_psum_valid", 32'(psum_valid_out), 0);
        chk("arst_f_out", 32'(f_out), 0);
        chk("arst_f_valid_out", 32'(f_valid_out), 0);
        chk("arst_w_out", 32'(w_out0), 0);
        chk("arst_chain_outs", 32'(|{w_out1, w_out2, fv1, fo1, pv1, po1, sf1,
                                     fv2, fo2, pv2, po2, sf2}), 0);
        #1 Rst_n = 1'b1;
        w_load = 1'b1; w_in = 8'd4; tick();
        w_load = 1'b0;
        f_valid_in = 1'b1; f_in = 8'd5; psum_in = 20'd1; tick();
        f_valid_in = 1'b0; f_in = '0; psum_in = '0;
        chk("arst_first_not_yet", 32'(psum_valid_out), 0);
        tick();
        chk("arst_first_out", 32'(psum_out), 21);
        chk("arst_first_valid", 32'(psum_valid_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_sa.md
# pe_mac_sa

Parametrised processing element for the convolution systolic array. It holds a stationary weight loaded through a shift chain and forwards features to its neighbour with one cycle of delay. It computes a 2-stage pipelined, optionally signed and saturating multiply-accumulate. It runs either in weight-stationary mode (partial sum flows through the PE) or in output-stationary mode (sum accumulates locally until a drain).

## Interface
Parameters:
- DW, 8: feature and weight width.
- PW, 20: partial-sum width; must be ≥ 2*DW.
- SIGNED, 1: 1 = two's-complement operands and sums; 0 = unsigned.
- SAT, 1: 1 = clamp sums to the PW range; 0 = wrap modulo 2^PW.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- compute_SA  in  1  global enable; 0 freezes every register except the weight chain.
- clear  in  1  synchronous clear of accumulator, sat_flag and pipeline valids.
- mode  in  1  0 = weight-stationary pass-through; 1 = output-stationary accumulate.
- w_load  in  1  weight shift enable.
- w_in  in  DW  weight from the upstream PE.
- w_out  out  DW  weight to the downstream PE (registered stationary weight).
- f_valid_in  in  1  feature valid.
- f_in  in  DW  feature.
- f_valid_out  out  1  registered feature valid to the neighbour.
- f_out  out  DW  registered feature to the neighbour.
- psum_in  in  PW  partial sum in; qualified by f_valid_in; mode 0 only.
- drain  in  1  mode 1: emit and zero the accumulator.
- psum_valid_out  out  1  psum_out is valid this cycle.
- psum_out  out  PW  partial sum / accumulated result.
- sat_flag  out  1  sticky; set when a clamp occurred.

## Operation
- Weight chain: while w_load=1, w_reg <= w_in and w_out = w_reg. In a chain of K PEs, K load cycles fill it. w_load is independent of compute_SA. clear does not alter w_reg.
- Feature forwarding, when compute_SA=1: f_out <= f_in and f_valid_out <= f_valid_in.
- Stage 1, when compute_SA=1:
  - prod <= f_in*w_reg (2*DW bits, signed or unsigned per SIGNED).
  - v1 <= f_valid_in.
  - psum_d <= psum_in.
  - drain_d <= drain.
- Stage 2, when compute_SA=1. prod is sign- or zero-extended to PW+1 bits.
  - mode 0: if v1, sum = psum_d + prod and psum_out <= clamp(sum), psum_valid_out <= 1. If v1=0, psum_valid_out <= 0 and psum_out holds.
  - mode 1: acc_next = acc + (v1 ? prod : 0), then clamped.
    - drain_d=0: acc <= acc_next and psum_valid_out <= 0.
    - drain_d=1: psum_out <= acc_next, psum_valid_out <= 1, acc <= 0. A product arriving in the drain cycle is included in the drained value.
- Clamp, when SAT=1:
  - SIGNED: range [-2^(PW-1), 2^(PW-1)-1].
  - Unsigned: range [0, 2^PW-1].
  - Any clamp sets sat_flag. When SAT=0 the result wraps and sat_flag stays 0.
- clear, taking priority over compute_SA: acc <= 0, sat_flag <= 0, v1 <= 0, drain_d <= 0, psum_valid_out <= 0. f_out and psum_out hold.
- compute_SA=0: all datapath registers hold, including psum_valid_out (a valid is held, not repeated as a new item downstream, because the neighbour is frozen too).
- mode is static while any valid is in flight. The result of changing mode mid-stream is undefined.

## Timing
- Reset: every output and internal register is 0, including w_out, f_out, f_valid_out, psum_out, psum_valid_out, sat_flag, acc and w_reg.
- Feature forward latency: 1 enabled cycle.
- MAC latency: f_in and psum_in sampled at edge n give psum_out and psum_valid_out at edge n+2 (2 enabled cycles).
- Drain latency: drain at edge n gives the result at edge n+2. It includes every valid feature sampled at or before edge n.
- Throughput: 1 MAC per enabled cycle, with no bubbles required.
- Rst_n deasserted mid-operation: everything is zeroed immediately, asynchronously. The first valid output can appear 2 enabled cycles after the first valid input following release.

## Test plan
- Weight chain: 3 PEs chained, w_load=1 for 3 cycles with w_in=5,6,7 → PE0/1/2 weights = 7/6/5; w_out of PE2 = 5.
- Mode 0 signed: w=-3, f_in=12, psum_in=100 at edge n → psum_out=64 and psum_valid_out=1 at edge n+2. Also f_out=12 at edge n+1.
- Saturation (PW=20): w=100, f=100, psum_in=524000 → psum_out=524287 and sat_flag=1. Then psum_in=-524000, f=-100 → psum_out=-524288. Then clear → sat_flag=0.
- Mode 1 accumulate and drain: w=2, f=1,2,3,4 on consecutive cycles with drain together with f=4 → one valid output of 20 two cycles later. acc=0 afterwards, so a following f=1 then drain gives 2.
- Stall: compute_SA=0 for 3 cycles in mid-stream → outputs, including psum_valid_out, frozen. Resuming yields the same sequence as an unstalled run. Weight load still works during the stall.
- Reset mid-stream: Rst_n low between pipeline stages → all outputs 0 asynchronously. The weight must be reloaded, and the next valid input gives an output 2 cycles later.
